uart_loader: RTL

Byte-stream download controller that sits behind the serial receiver and sequences its output into memory writes. It takes the receiver's one-cycle `rx_done`/`rx_data` strobe, parses framed commands (block write, execute), drives a single-beat memory write port with request/acknowledge handshake, verifies a checksum, and holds the CPU halted while a block is loading. It is used to side-load cartridge/RAM images over the UART without host-core involvement.

---
 rtl/uart_loader_pkg.sv | 10 +
 rtl/uart_loader_hold.sv | 36 +++
 rtl/uart_loader.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and framing constants for the UART download controller.
package uart_loader_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADH, S_ADL, S_LNH, S_LNL, S_DATA, S_WAIT_ACK, S_CSUM
  } state_t;

  localparam logic [7:0] SYNC  = 8'h55;
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_G = 8'h47;
endpackage

// File: rtl/uart_loader_hold.sv
// One-byte holding register between the serial receiver strobe and the frame FSM.
module uart_loader_hold (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_rx_done,
  input  logic [7:0] i_rx_data,
  input  logic       i_take,
  output logic       o_full,
  output logic [7:0] o_byte,
  output logic       o_ovr
);
  logic       r_full;
  logic [7:0] r_byte;
  logic       w_ovr;

  // A byte arriving in the same cycle the held one is taken is not an overrun.
  assign w_ovr  = i_rx_done & r_full & ~i_take;
  assign o_full = r_full;
  assign o_byte = r_byte;
  assign o_ovr  = w_ovr;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_full <= 1'b0;
      r_byte <= 8'h00;
    end else if (w_ovr) begin
      // Overrun aborts the frame, so the stale byte is flushed too.
      r_full <= 1'b0;
    end else if (i_rx_done) begin
      r_byte <= i_rx_data;
      r_full <= 1'b1;
    end else if (i_take) begin
      r_full <= 1'b0;
    end
  end
endmodule

// File: rtl/uart_loader.sv
// Framed command parser: turns received bytes into memory writes and exec requests.
module uart_loader #(
  parameter int          ADDR_W  = 16,
  parameter logic [23:0] TIMEOUT = 24'd5_000_000
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_done,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_data,
  output logic              o_mem_we,
  input  logic              i_mem_ack,
  output logic              o_cpu_halt,
  output logic [ADDR_W-1:0] o_exec_addr,
  output logic              o_exec,
  output logic              o_load_done,
  output logic              o_err_csum,
  output logic              o_err_ovr,
  output logic              o_err_tmo
);
  import uart_loader_pkg::*;

  state_t            r_state;
  logic              r_is_w;
  logic [7:0]        r_adh;
  logic [7:0]        r_lnh;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_len;
  logic [7:0]        r_sum;
  logic [23:0]       r_tmo;

  logic              w_full;
  logic [7:0]        w_byte;
  logic              w_ovr;
  logic              w_take;
  logic              w_ack;
  logic              w_tmo_hit;
  logic [7:0]        w_sum;

  uart_loader_hold u_hold (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_rx_done (i_rx_done),
    .i_rx_data (i_rx_data),
    .i_take    (w_take),
    .o_full    (w_full),
    .o_byte    (w_byte),
    .o_ovr     (w_ovr)
  );

  assign w_take    = w_full && (r_state != S_WAIT_ACK);
  assign w_ack     = (r_state == S_WAIT_ACK) && i_mem_ack;
  assign w_sum     = r_sum + w_byte;
  assign w_tmo_hit = (r_state != S_IDLE) && !w_take && !w_ack &&
                     (r_tmo == TIMEOUT - 24'd1);

  // Idle-gap counter: any forward progress (byte or ack) restarts it.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                                             r_tmo <= '0;
    else if (r_state == S_IDLE || w_take || w_ack || w_tmo_hit) r_tmo <= '0;
    else                                                        r_tmo <= r_tmo + 24'd1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_is_w      <= 1'b0;
      r_adh       <= '0;
      r_lnh       <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_sum       <= '0;
      o_mem_addr  <= '0;
      o_mem_data  <= '0;
      o_mem_we    <= 1'b0;
      o_cpu_halt  <= 1'b0;
      o_exec_addr <= '0;
      o_exec      <= 1'b0;
      o_load_done <= 1'b0;
      o_err_csum  <= 1'b0;
      o_err_ovr   <= 1'b0;
      o_err_tmo   <= 1'b0;
    end else begin
      o_exec      <= 1'b0;
      o_load_done <= 1'b0;
      if (w_ovr) begin
        o_err_ovr  <= 1'b1;
        o_mem_we   <= 1'b0;
        o_cpu_halt <= 1'b0;
        r_state    <= S_IDLE;
      end else if (w_tmo_hit) begin
        // An abandoned write is simply dropped; the host must resend the frame.
        o_err_tmo  <= 1'b1;
        o_mem_we   <= 1'b0;
        o_cpu_halt <= 1'b0;
        r_state    <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (w_take && w_byte == SYNC) begin
            o_err_csum <= 1'b0;
            o_err_ovr  <= 1'b0;
            o_err_tmo  <= 1'b0;
            r_sum      <= '0;
            r_state    <= S_CMD;
          end
          S_CMD: if (w_take) begin
            if (w_byte == CMD_W || w_byte == CMD_G) begin
              r_is_w     <= (w_byte == CMD_W);
              o_cpu_halt <= (w_byte == CMD_W);
              r_sum      <= w_sum;
              r_state    <= S_ADH;
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_ADH: if (w_take) begin
            r_adh   <= w_byte;
            r_sum   <= w_sum;
            r_state <= S_ADL;
          end
          S_ADL: if (w_take) begin
            r_addr  <= ADDR_W'({r_adh, w_byte});
            r_sum   <= w_sum;
            r_state <= S_LNH;
          end
          S_LNH: if (w_take) begin
            r_lnh   <= w_byte;
            r_sum   <= w_sum;
            r_state <= S_LNL;
          end
          S_LNL: if (w_take) begin
            r_len   <= {r_lnh, w_byte};
            r_sum   <= w_sum;
            r_state <= (r_is_w && {r_lnh, w_byte} != 16'd0) ? S_DATA : S_CSUM;
          end
          S_DATA: if (w_take) begin
            o_mem_addr <= r_addr;
            o_mem_data <= w_byte;
            o_mem_we   <= 1'b1;
            r_sum      <= w_sum;
            r_state    <= S_WAIT_ACK;
          end
          S_WAIT_ACK: if (w_ack) begin
            o_mem_we <= 1'b0;
            r_addr   <= r_addr + ADDR_W'(1);
            r_len    <= r_len - 16'd1;
            r_state  <= (r_len == 16'd1) ? S_CSUM : S_DATA;
          end
          S_CSUM: if (w_take) begin
            if (w_sum == 8'h00) begin
              if (r_is_w) begin
                o_load_done <= 1'b1;
              end else begin
                o_exec_addr <= r_addr;
                o_exec      <= 1'b1;
              end
            end else begin
              o_err_csum <= 1'b1;
            end
            o_cpu_halt <= 1'b0;
            r_state    <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
